// File: rtl/mux2_pkg.sv
// rtl/mux2_pkg.sv - shared types and defaults for the mux2 skid stage
package mux2_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int DEFAULT_N = 8;

endpackage

// File: rtl/skid_reg.sv
// rtl/skid_reg.sv - N-bit data register with synchronous reset and load enable
module skid_reg #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // Capture d when load is set; cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mux2_skid_stage.sv
// rtl/mux2_skid_stage.sv - 2-entry skid stage after the mux2; MUX2_SKID_STATS_EN adds xfer_count
module mux2_skid_stage
    import mux2_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [N-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef MUX2_SKID_STATS_EN
    ,
    output logic [CNT_W-1:0] xfer_count
`endif
);

    skid_state_t  state_q;
    skid_state_t  state_d;
    logic [N-1:0] main_q;
    logic [N-1:0] skid_q;
    logic [N-1:0] main_d;
    logic         main_load;
    logic         skid_load;
    logic         in_xfer;
    logic         out_xfer;

    // All handshake outputs decode registered state only, so in_ready never
    // has a combinational path from out_ready.
    assign out_data  = main_q;
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and data-register load controls; flush discards everything
    // and suppresses loads so a word accepted in the flush cycle is dropped.
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_data;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_load = 1'b1;
                        state_d   = BUSY;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer) begin
                        skid_load = 1'b1;
                        state_d   = FULL;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_load = 1'b1;
                        main_d    = skid_q;
                        state_d   = BUSY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    skid_reg #(.N(N)) u_main_reg (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    skid_reg #(.N(N)) u_skid_reg (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_data),
        .q    (skid_q)
    );

`ifdef MUX2_SKID_STATS_EN
    logic [CNT_W-1:0] count_q;

    // Output transfer counter; wraps naturally and survives flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (out_xfer) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign xfer_count = count_q;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_mux2_skid_stage.sv
// tb/tb_mux2_skid_stage.sv - directed scoreboard bench for mux2_skid_stage
module tb_mux2_skid_stage;

    localparam int N        = 8;
    localparam int TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic [N-1:0]        in_data;
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0]        out_data;
    logic                out_valid;
    logic                out_ready;
`ifdef MUX2_SKID_STATS_EN
    logic [TB_CNT_W-1:0] xfer_count;
`endif

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [N-1:0] sb[$];
    int          exp_cnt  = 0;
    bit          model_valid = 1'b0;

    always #5 clk = ~clk;

    mux2_skid_stage #(.N(N), .CNT_W(TB_CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef MUX2_SKID_STATS_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, pop on output transfer, clock once,
    // then advance the model (rst > flush > handshake).
    task automatic step();
        logic         acc;
        logic         pop;
        logic [N-1:0] popped;
        if (model_valid) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, (sb.size() < 2)});
            chk("out_valid", {31'd0, out_valid}, {31'd0, (sb.size() > 0)});
`ifdef MUX2_SKID_STATS_EN
            chk("xfer_count", 32'(xfer_count), 32'(exp_cnt % (1 << TB_CNT_W)));
`endif
        end
        acc = model_valid && in_valid && (sb.size() < 2);
        pop = model_valid && out_ready && (sb.size() > 0);
        if (!rst && !flush && pop) begin
            popped = sb.pop_front();
            chk("out_data", 32'(out_data), 32'(popped));
        end
        @(posedge clk);
        #1;
        if (rst) begin
            sb.delete();
            exp_cnt     = 0;
            model_valid = 1'b1;
        end else begin
            if (pop) exp_cnt++;
            if (flush) sb.delete();
            else if (acc) sb.push_back(in_data);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;

        // Reset then idle
        step(); step();
        rst = 1'b0;
        step();
        chk("reset_out_data", 32'(out_data), 32'h00);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Pass-through: never reaches FULL
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h0F; step();
        chk("pass_first", 32'(out_data), 32'h0F);
        in_data = 8'hF0; step();
        chk("pass_second", 32'(out_data), 32'hF0);
        in_valid = 1'b0; step(); step();

        // Backpressure: C3 held upstream until space frees
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hA1; step();
        in_data = 8'hB2; step();
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        in_data = 8'hC3; step(); step();
        out_ready = 1'b1; step();
        step();
        in_valid = 1'b0; step(); step();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Flush in FULL with a competing input
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11; step();
        in_data = 8'h22; step();
        flush = 1'b1; in_data = 8'h33; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1; step(); step();

        // Reset mid-operation in FULL
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h44; step();
        in_data = 8'h55; step();
        in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1; step();
        rst = 1'b0;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_data", 32'(out_data), 32'h00);
        step();

`ifdef MUX2_SKID_STATS_EN
        // Five transfers then a flush; counter keeps its value
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h60 + i); step();
        end
        in_valid = 1'b0; step(); step();
        out_ready = 1'b0; flush = 1'b1; step();
        flush = 1'b0;
        chk("stats_after_flush", 32'(xfer_count), 32'd5);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h70 + i); step();
        end
        in_valid = 1'b0; step(); step();
        chk("stats_max", 32'(xfer_count), 32'd15);
        in_valid = 1'b1; in_data = 8'h99; step();
        in_valid = 1'b0; step(); step();
        chk("stats_wrap", 32'(xfer_count), 32'd0);
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
